// File: rtl/sram_1r1w_be.sv
// rtl/sram_1r1w_be.sv - 1R1W synchronous memory with byte enables, registered read and clear sequencer
module sram_1r1w_be #(
  parameter int DATA_W   = 32,
  parameter int LANE_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int RDW_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/LANE_W-1:0] wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_err
);

  localparam int LANES = DATA_W / LANE_W;
  // One extra bit so DEPTH == 2**ADDR_W is representable in range checks.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_ptr, clr_ptr_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_fire, rd_fire;
  logic                wr_in_range, rd_in_range;
  logic [DATA_W-1:0]   rd_word;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;

  // Next-state and port gating: clearing owns the array, clr_req preempts same-cycle accesses.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    busy         = 1'b1;
    wr_fire      = 1'b0;
    rd_fire      = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == LAST_ADDR) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        busy = 1'b0;
        if (clr_req) begin
          state_next   = S_CLEAR;
          clr_ptr_next = '0;
        end else begin
          wr_fire = wr_en && wr_in_range;
          rd_fire = rd_en;
        end
      end
    endcase
  end

  // State register; reset from any state restarts the clear at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // Array update: one zeroed word per cycle while clearing, otherwise lane-masked writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_fire) begin
        for (int k = 0; k < LANES; k++) begin
          if (wr_be[k]) begin
            mem[wr_addr][k*LANE_W +: LANE_W] <= wr_data[k*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // Read word selection, merging in the concurrent write's enabled lanes in bypass mode.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE != 0 && wr_fire && wr_addr == rd_addr) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_be[k]) begin
          rd_word[k*LANE_W +: LANE_W] = wr_data[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Registered read port; out-of-range reads return zero with an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (rd_fire) begin
      rd_valid <= 1'b1;
      if (rd_in_range) begin
        rd_data <= rd_word;
        rd_err  <= 1'b0;
      end else begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_1r1w_be.sv
// tb/tb_sram_1r1w_be.sv - directed self-checking bench for sram_1r1w_be
module tb_sram_1r1w_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;

  logic        busy0, busy1, rd_valid0, rd_valid1, rd_err0, rd_err1;
  logic [31:0] rd_data0, rd_data1;

  logic        c_wr_en = 1'b0;
  logic [4:0]  c_wr_addr = '0;
  logic [3:0]  c_wr_be = '0;
  logic [31:0] c_wr_data = '0;
  logic        c_rd_en = 1'b0;
  logic [4:0]  c_rd_addr = '0;
  logic        c_busy, c_rd_valid, c_rd_err;
  logic [31:0] c_rd_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_1r1w_be #(.DEPTH(32), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_err(rd_err0)
  );

  sram_1r1w_be #(.DEPTH(32), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_err(rd_err1)
  );

  sram_1r1w_be #(.DEPTH(20), .RDW_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .clr_req(1'b0), .busy(c_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_be(c_wr_be), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid), .rd_err(c_rd_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_both(input string tag, input logic [4:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_d0"}, rd_data0, exp);
    check({tag, "_d1"}, rd_data1, exp);
    check({tag, "_v"}, {30'd0, rd_valid1, rd_valid0}, 32'd3);
  endtask

  task automatic busy_len(input string tag, output int cnt);
    cnt = 0;
    while (busy0 && cnt < 100) begin
      cnt++;
      tick();
    end
    check({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
  endtask

  task automatic c_wr(input logic [4:0] a, input logic [31:0] d);
    c_wr_en = 1'b1; c_wr_addr = a; c_wr_data = d; c_wr_be = 4'hF;
    tick();
    c_wr_en = 1'b0;
  endtask

  int cnt;
  logic any_valid;
  int vcnt;

  initial begin
    // T1: reset values, clear length, all words zero
    tick();
    tick();
    check("rst_busy", {31'd0, busy0}, 32'd1);
    check("rst_rd_data", rd_data0, 32'd0);
    check("rst_rd_valid", {30'd0, rd_valid1, rd_valid0}, 32'd0);
    rst = 1'b0;
    busy_len("t1", cnt);
    check("t1_busy_cycles", cnt, 32'd32);
    for (int a = 0; a < 32; a++) rd_both("t1_rd", 5'(a), 32'd0);
    tick();
    check("t1_valid_drop", {30'd0, rd_valid1, rd_valid0}, 32'd0);

    // T2: lane enables
    wr(5'd5, 32'hAABBCCDD, 4'b1111);
    wr(5'd5, 32'h11223344, 4'b0101);
    wr(5'd5, 32'hFFFFFFFF, 4'b0000);
    rd_both("t2_be", 5'd5, 32'hAA22CC44);

    // T3: read-during-write to the same address
    wr(5'd7, 32'h12345678, 4'hF);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 5'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("t3_rdw_old", rd_data0, 32'h12345678);
    check("t3_rdw_new", rd_data1, 32'h1234FFFF);
    rd_both("t3_after", 5'd7, 32'h1234FFFF);
    // different addresses: no interaction
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h0BADF00D; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 5'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("t3_diff0", rd_data0, 32'hAA22CC44);
    check("t3_diff1", rd_data1, 32'hAA22CC44);

    // T4: fill, then clear with a competing write
    for (int a = 0; a < 32; a++) wr(5'(a), 32'hDEADBEEF, 4'hF);
    rd_both("t4_fill", 5'd17, 32'hDEADBEEF);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55555555; wr_be = 4'hF;
    tick();
    clr_req = 1'b0; wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd3;
    any_valid = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 100) begin
      cnt++;
      tick();
      any_valid = any_valid | rd_valid0 | rd_valid1;
    end
    rd_en = 1'b0;
    check("t4_busy_cycles", cnt, 32'd32);
    check("t4_no_valid_busy", {31'd0, any_valid}, 32'd0);
    for (int a = 0; a < 32; a++) rd_both("t4_rd", 5'(a), 32'd0);

    // T5: reset in the middle of a clear
    wr(5'd2, 32'hCAFEF00D, 4'hF);
    wr(5'd15, 32'hCAFEF00D, 4'hF);
    wr(5'd31, 32'hCAFEF00D, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t5_busy_mid", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len("t5", cnt);
    check("t5_busy_cycles", cnt, 32'd32);
    for (int a = 0; a < 32; a++) rd_both("t5_rd", 5'(a), 32'd0);

    // T6: DEPTH=20 range handling and streaming reads
    check("t6_ready", {31'd0, c_busy}, 32'd0);
    for (int a = 0; a < 20; a++) c_wr(5'(a), 32'h100 + a);
    c_wr(5'd25, 32'hFFFFFFFF);
    c_rd_en = 1'b1; c_rd_addr = 5'd25;
    tick();
    c_rd_en = 1'b0;
    check("t6_oor_data", c_rd_data, 32'd0);
    check("t6_oor_err", {30'd0, c_rd_valid, c_rd_err}, 32'd3);
    tick();
    check("t6_err_drop", {30'd0, c_rd_valid, c_rd_err}, 32'd0);
    check("t6_hold_data", c_rd_data, 32'd0);
    vcnt = 0;
    c_rd_en = 1'b1;
    for (int a = 0; a < 20; a++) begin
      c_rd_addr = 5'(a);
      tick();
      if (c_rd_valid && !c_rd_err) vcnt++;
      check("t6_stream", c_rd_data, 32'h100 + a);
    end
    c_rd_en = 1'b0;
    check("t6_stream_valid", vcnt, 32'd20);
    tick();
    check("t6_stream_end", {31'd0, c_rd_valid}, 32'd0);
    check("t6_hold_last", c_rd_data, 32'h113);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
